// File: rtl/thirty_two_bit_dff.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : thirty_two_bit_dff
//  Purpose  : WIDTH-bit rising-edge D flip-flop bank with asynchronous,
//             active-high reset. Optionally carries a registered even-parity
//             bit of the stored word.
//  Ports    : Q      - output [WIDTH-1:0], registered data
//             D      - input  [WIDTH-1:0], data to be registered
//             clk    - input, rising-edge sampling clock
//             resetb - input, asynchronous reset, active-high (1 = reset)
//             Qp     - output, registered even parity of Q
//                      (present only when DFF_PARITY_EN is defined)
//  Config   : DFF_PARITY_EN - when defined, adds the Qp output and its flop
//  Revision : 1.0 - initial release
// ============================================================================
module thirty_two_bit_dff #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             clk,
  input  logic             resetb
`ifdef DFF_PARITY_EN
  ,
  output logic             Qp
`endif
);

  logic [WIDTH-1:0] r_q;

  // The whole word is one register so every bit updates on the same edge.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= D;
    end
  end

  assign Q = r_q;

`ifdef DFF_PARITY_EN
  logic r_qp;

  // Parity is computed from D and registered alongside it, so Qp always
  // matches the XOR-reduction of Q without a combinational path through Q.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      r_qp <= ^RESET_VALUE;
    end else begin
      r_qp <= ^D;
    end
  end

  assign Qp = r_qp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thirty_two_bit_dff.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_thirty_two_bit_dff
//  Purpose  : Self-checking bench for thirty_two_bit_dff: hand-written reset,
//             release, async-reset, coincident-reset and glitch sequences,
//             followed by a table of vectors checked through a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_thirty_two_bit_dff;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic             clk;
  logic             resetb;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
`ifdef DFF_PARITY_EN
  logic             Qp;
`endif

  thirty_two_bit_dff #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV)
  ) dut (
    .Q      (Q),
    .D      (D),
    .clk    (clk),
    .resetb (resetb)
`ifdef DFF_PARITY_EN
    ,
    .Qp     (Qp)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  typedef struct {
    logic [31:0] d;
    logic        rst;
    logic [31:0] exp_q;
    logic        exp_p;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] sb_q[$];
  logic        sb_p[$];
  int          n_cmp;
  int          n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_par(input string name, input logic exp);
`ifdef DFF_PARITY_EN
    check(name, {31'd0, Qp}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  task automatic sb_check(input int idx);
    logic [31:0] eq;
    logic        ep;
    eq = sb_q.pop_front();
    ep = sb_p.pop_front();
    check($sformatf("vec%0d_q", idx), Q, eq);
    check_par($sformatf("vec%0d_p", idx), ep);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1};
    vecs[1] = '{32'hAAAA_AAAA, 1'b0, 32'hAAAA_AAAA, 1'b0};
    vecs[2] = '{32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1};
    vecs[3] = '{32'h8765_4321, 1'b0, 32'h8765_4321, 1'b1};
    vecs[4] = '{32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    // Reset from time 0: Q at reset value through several edges.
    resetb = 1'b1;
    D      = '0;
    #0.1;
    check("reset_t0", Q, RV);
    check_par("reset_t0_p", 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", Q, RV);
    end

    // D activity under reset must not reach Q.
    @(negedge clk);
    D = 32'hAAAA_AAAA;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold_d", Q, RV);
      check_par("reset_hold_p", 1'b0);
    end

    // Release: first rising edge captures, and not before.
    resetb = 1'b0;
    D      = 32'h0000_0000;
    @(negedge clk);
    check("release_zero", Q, 32'h0000_0000);
    D = 32'hFFFF_FFFF;
    #0.8;
    check("no_early_capture", Q, 32'h0000_0000);
    @(negedge clk);
    check("first_edge_capture", Q, 32'hFFFF_FFFF);

    // Asynchronous reset between edges clears Q with no clock edge.
    #0.4;
    resetb = 1'b1;
    #0.1;
    check("async_reset", Q, RV);
    @(negedge clk);
    check("async_reset_hold", Q, RV);

    // Reset asserted exactly at a rising edge wins over capture.
    resetb = 1'b0;
    D      = 32'hFFFF_FFFF;
    @(negedge clk);
    check("pre_coincident", Q, 32'hFFFF_FFFF);
    D = 32'h5A5A_5A5A;
    @(posedge clk);
    resetb = 1'b1;
    #0.5;
    check("coincident_reset", Q, RV);

    // Glitches on D between edges are ignored; falling edges do nothing.
    @(negedge clk);
    resetb = 1'b0;
    D      = 32'h1234_5678;
    #0.3;
    D = 32'hDEAD_BEEF;
    #0.3;
    D = 32'h1234_5678;
    @(posedge clk);
    #0.3;
    D = 32'h0F0F_0F0F;
    @(negedge clk);
    check("glitch_hold", Q, 32'h1234_5678);
    #0.2;
    check("negedge_no_effect", Q, 32'h1234_5678);
    D = 32'h8765_4321;
    @(negedge clk);
    check("follow_next", Q, 32'h8765_4321);

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) sb_check(i - 1);
      D      = vecs[i].d;
      resetb = vecs[i].rst;
      sb_q.push_back(vecs[i].exp_q);
      sb_p.push_back(vecs[i].exp_p);
    end
    @(negedge clk);
    sb_check(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
